// File: rtl/regs_hilo_file.sv
// Architectural GPR file plus HI/LO pair, committed from the MEM/WB write-back bus.
// Define REGS_WB_BYPASS_EN to forward same-cycle write-back data onto the read ports and HI/LO.
module regs_hilo_file #(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_write_addr,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  wb_write_hilo_enable,
  input  logic [DATA_WIDTH-1:0] wb_write_hi_data,
  input  logic [DATA_WIDTH-1:0] wb_write_lo_data,
  input  logic                  read_enable1,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  output logic [DATA_WIDTH-1:0] read_data1,
  input  logic                  read_enable2,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] hi_data,
  output logic [DATA_WIDTH-1:0] lo_data,
  output logic [15:0]           commit_count
);

  logic [DATA_WIDTH-1:0] gpr [REG_COUNT];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  gpr_commit;

  assign gpr_commit = wb_write_enable && (wb_write_addr != '0) &&
                      (32'(wb_write_addr) < REG_COUNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) gpr[i] <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      commit_count <= '0;
    end else begin
      if (gpr_commit) gpr[wb_write_addr] <= wb_write_data;
      if (wb_write_hilo_enable) begin
        hi_q <= wb_write_hi_data;
        lo_q <= wb_write_lo_data;
      end
      // A GPR and a HI/LO commit on the same edge count as one event
      if (gpr_commit || wb_write_hilo_enable) commit_count <= commit_count + 16'd1;
    end
  end

  // Outputs are gated by reset so the forwarding path also reads 0 while reset is held
  always_comb begin
    read_data1 = '0;
    if (reset && read_enable1 && (read_addr1 != '0) && (32'(read_addr1) < REG_COUNT)) begin
      read_data1 = gpr[read_addr1];
`ifdef REGS_WB_BYPASS_EN
      if (gpr_commit && (wb_write_addr == read_addr1)) read_data1 = wb_write_data;
`endif
    end
  end

  always_comb begin
    read_data2 = '0;
    if (reset && read_enable2 && (read_addr2 != '0) && (32'(read_addr2) < REG_COUNT)) begin
      read_data2 = gpr[read_addr2];
`ifdef REGS_WB_BYPASS_EN
      if (gpr_commit && (wb_write_addr == read_addr2)) read_data2 = wb_write_data;
`endif
    end
  end

  always_comb begin
    hi_data = '0;
    lo_data = '0;
    if (reset) begin
      hi_data = hi_q;
      lo_data = lo_q;
`ifdef REGS_WB_BYPASS_EN
      if (wb_write_hilo_enable) begin
        hi_data = wb_write_hi_data;
        lo_data = wb_write_lo_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regs_hilo_file.sv
// Scoreboard bench for regs_hilo_file: driver pushes model predictions, negedge monitor compares.
module tb_regs_hilo_file;

  logic        clock;
  logic        reset;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        wb_write_hilo_enable;
  logic [31:0] wb_write_hi_data;
  logic [31:0] wb_write_lo_data;
  logic        read_enable1;
  logic [4:0]  read_addr1;
  logic [31:0] read_data1;
  logic        read_enable2;
  logic [4:0]  read_addr2;
  logic [31:0] read_data2;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [15:0] commit_count;

  regs_hilo_file #(.REG_COUNT(32), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data), .wb_write_hilo_enable(wb_write_hilo_enable),
    .wb_write_hi_data(wb_write_hi_data), .wb_write_lo_data(wb_write_lo_data),
    .read_enable1(read_enable1), .read_addr1(read_addr1), .read_data1(read_data1),
    .read_enable2(read_enable2), .read_addr2(read_addr2), .read_data2(read_data2),
    .hi_data(hi_data), .lo_data(lo_data), .commit_count(commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: plain arrays and an integer event counter
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_cnt;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "rd1", read_data1, mon_e.rd1);
      chk(mon_e.name, "rd2", read_data2, mon_e.rd2);
      chk(mon_e.name, "hi", hi_data, mon_e.hi);
      chk(mon_e.name, "lo", lo_data, mon_e.lo);
      chk(mon_e.name, "cnt", 32'(commit_count), 32'(mon_e.cnt));
    end
  end

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (!reset || !en || a == 5'd0) return 32'd0;
`ifdef REGS_WB_BYPASS_EN
    if (wb_write_enable && wb_write_addr == a) return wb_write_data;
`endif
    return m_gpr[a];
  endfunction

  task automatic push_expected(input string nm);
    exp_t e;
    e.name = nm;
    e.rd1  = model_read(read_enable1, read_addr1);
    e.rd2  = model_read(read_enable2, read_addr2);
    e.hi   = reset ? m_hi : 32'd0;
    e.lo   = reset ? m_lo : 32'd0;
`ifdef REGS_WB_BYPASS_EN
    if (reset && wb_write_hilo_enable) begin
      e.hi = wb_write_hi_data;
      e.lo = wb_write_lo_data;
    end
`endif
    e.cnt  = 16'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    m_cnt = 0;
  endtask

  task automatic model_commit();
    bit g;
    g = wb_write_enable && (wb_write_addr != 5'd0);
    if (g) m_gpr[wb_write_addr] = wb_write_data;
    if (wb_write_hilo_enable) begin
      m_hi = wb_write_hi_data;
      m_lo = wb_write_lo_data;
    end
    if (g || wb_write_hilo_enable) m_cnt = (m_cnt + 1) % 65536;
  endtask

  // Called at posedge+1; drives one cycle, predicts, then steps the model across the edge
  task automatic cyc(input string nm, input bit chk_en,
                     input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit hwe, input logic [31:0] hd, input logic [31:0] ld,
                     input bit re1, input logic [4:0] ra1, input bit re2, input logic [4:0] ra2);
    wb_write_enable      = we;
    wb_write_addr        = wa;
    wb_write_data        = wd;
    wb_write_hilo_enable = hwe;
    wb_write_hi_data     = hd;
    wb_write_lo_data     = ld;
    read_enable1         = re1;
    read_addr1           = ra1;
    read_enable2         = re2;
    read_addr2           = ra2;
    if (chk_en) push_expected(nm);
    @(posedge clock);
    if (reset) model_commit();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] wa;
    reset = 1'b0;
    model_clear();
    wb_write_enable = 1'b1; wb_write_addr = 5'd9; wb_write_data = 32'hFFFF_FFFF;
    wb_write_hilo_enable = 1'b1; wb_write_hi_data = 32'h1111_1111; wb_write_lo_data = 32'h2222_2222;
    read_enable1 = 1'b1; read_addr1 = 5'd9; read_enable2 = 1'b1; read_addr2 = 5'd1;
    push_expected("reset_init");
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    cyc("gpr_wr7", 1, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 0, 1, 5'd7, 1, 5'd7);
    cyc("gpr_rd7", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd7, 1, 5'd7);
    cyc("rd2_off", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd7, 0, 5'd7);

    cyc("r0_wr", 1, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 1, 5'd0);
    cyc("r0_rd", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd0, 1, 5'd7);

    cyc("bypass_r3", 1, 1, 5'd3, 32'hA5A5_A5A5, 0, 0, 0, 1, 5'd3, 1, 5'd3);
    cyc("after_r3", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd3, 1, 5'd7);

    cyc("hilo_r4", 1, 1, 5'd4, 32'd3, 1, 32'd1, 32'd2, 1, 5'd4, 0, 5'd0);
    cyc("hilo_r4_post", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd4, 1, 5'd3);

    cyc("wr_r5", 1, 1, 5'd5, 32'h0000_1234, 0, 0, 0, 1, 5'd5, 0, 5'd0);
    cyc("rd_r5", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd5, 1, 5'd7);

    // Mid-cycle reset with a write pending: no edge between assertion and the check
    wb_write_enable = 1'b1; wb_write_addr = 5'd5; wb_write_data = 32'hCAFE_F00D;
    wb_write_hilo_enable = 1'b1; wb_write_hi_data = 32'h3; wb_write_lo_data = 32'h4;
    read_enable1 = 1'b1; read_addr1 = 5'd5; read_enable2 = 1'b1; read_addr2 = 5'd7;
    reset = 1'b0;
    model_clear();
    push_expected("async_reset");
    @(posedge clock); #1;
    push_expected("reset_hold");
    @(posedge clock); #1;
    reset = 1'b1;
    cyc("post_reset", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd5, 1, 5'd7);

    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom_range(0, 31));
      cyc("random", 1,
          1'($urandom_range(0, 1)), wa, $urandom,
          ($urandom_range(0, 3) == 0), $urandom, $urandom,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)));
    end

    while (m_cnt != 65535) cyc("preload", 0, 0, 5'd0, 32'd0, 1, $urandom, $urandom, 0, 5'd0, 0, 5'd0);
    cyc("wrap_pre", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd7, 1, 5'd3);
    cyc("wrap_commit", 1, 1, 5'd9, 32'h0BAD_F00D, 0, 0, 0, 1, 5'd9, 0, 5'd0);
    cyc("wrap_post", 1, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd9, 1, 5'd4);

    @(negedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regs_hilo_file.md
# regs_hilo_file

Architectural state sink for the MIPS pipeline's write-back interface. Holds the 32 general-purpose registers and the HI/LO pair, and commits the `wb_*` signals registered by the MEM/WB stage on the clock edge. Serves two combinational GPR read ports and one HI/LO read port to the decode and execute stages.

## Interface
Parameters:
- `REG_COUNT`, 32: number of GPRs; register 0 is hardwired to zero.
- `DATA_WIDTH`, 32: register data width; equals the `REGS_DATA_BUS` width.
- `ADDR_WIDTH`, 5: register address width; equals the `REGS_ADDR_BUS` width.

Ports:
- `clock`  in  1  single clock; all state updates occur on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `wb_write_enable`  in  1  commits a GPR write this edge.
- `wb_write_addr`  in  5  destination GPR.
- `wb_write_data`  in  32  GPR write data.
- `wb_write_hilo_enable`  in  1  commits HI and LO together this edge.
- `wb_write_hi_data`  in  32  new HI value.
- `wb_write_lo_data`  in  32  new LO value.
- `read_enable1`, `read_enable2`  in  1  port read strobes.
- `read_addr1`, `read_addr2`  in  5  port read addresses.
- `read_data1`, `read_data2`  out  32  combinational read data.
- `hi_data`, `lo_data`  out  32  current HI/LO values as seen by execute.
- `commit_count`  out  16  number of committed write events; wraps modulo 2^16.

## Operation
Reset (`reset`=0, asynchronous):
- All GPRs, HI, LO and `commit_count` are forced to 0.
- `read_data1`, `read_data2`, `hi_data` and `lo_data` read 0 while reset is held.

GPR write:
- On a rising edge with `reset`=1, `wb_write_enable`=1 and `wb_write_addr`≠0, `wb_write_data` is stored.
- A write addressed to 0 is discarded, and register 0 always reads 0.

HI/LO write:
- On a rising edge with `wb_write_hilo_enable`=1, HI and LO are written together.
- This path is independent of the GPR write; both may commit on the same edge.

Read ports (each port independently):
- If `read_enable`=0, the port outputs 0.
- If the address is 0, the port outputs 0.
- If the bypass feature is compiled in, and `wb_write_enable`=1 with `wb_write_addr` equal to the read address (nonzero), the port outputs `wb_write_data`.
- Otherwise the port outputs the stored register value.
- Port 1 and port 2 may read the same address; both return identical data.

HI/LO outputs:
- If the bypass feature is compiled in and `wb_write_hilo_enable`=1, `hi_data`/`lo_data` show the incoming HI/LO data.
- Otherwise they show the stored HI/LO values.

`commit_count`:
- Increments by 1 per edge on which at least one committing write occurs: an effective GPR write (nonzero address) or a HI/LO write.
- A simultaneous GPR and HI/LO write counts once.
- 0xFFFF wraps to 0x0000.

## Timing
- Write latency is 1 edge: data presented before edge N is architectural after edge N.
- Read ports and HI/LO outputs are purely combinational from the addresses, enables, state and (with bypass) the `wb_*` inputs. There is no read latency.
- Reset assertion takes effect without a clock. On deassertion, the first write can commit on the next rising edge.
- If reset asserts mid-cycle while a write is pending, the write is lost and state is 0.

## Configuration
- `REGS_WB_BYPASS_EN` defined:
  - Same-cycle write-through forwarding is enabled on both GPR read ports and on `hi_data`/`lo_data`.
  - A value being written becomes visible in the same cycle as the write.
- Not defined:
  - Reads return only stored state.
  - A value becomes visible one cycle after its write edge.
  - The pipeline must stall or forward externally for one extra cycle.

## Test plan
- Reset: drive `reset`=0 mid-simulation after writing r5=0x1234 → r5, HI, LO and `commit_count` all read 0 immediately, without a clock edge.
- GPR write and read: write r7=0xDEADBEEF, then read port 1 and port 2 at addr 7 with enables=1 → both return 0xDEADBEEF. With `read_enable2`=0, port 2 returns 0.
- Zero register: write addr 0 with 0xFFFFFFFF → reads of r0 return 0 and `commit_count` is unchanged.
- Bypass: in the same cycle, write r3=0xA5A5A5A5 and read addr 3:
  - With `REGS_WB_BYPASS_EN`, returns 0xA5A5A5A5 before the edge.
  - Without it, returns the old value (0) until after the edge.
- HI/LO with a simultaneous GPR write: on one edge, write HI=0x1, LO=0x2 and r4=0x3 → after the edge, `hi_data`=1, `lo_data`=2, r4=3, and `commit_count` advanced by exactly 1.
- Counter wrap: preload via 65535 commits → `commit_count`=0xFFFF; the next commit gives 0x0000.
